// File: rtl/tlul_xbar_mn.sv
// ----------------------------------------------------------------------------
// tlul_xbar_mn -- M-host to N-device TileLink-UL crossbar with one shared path.
//
// Purpose:
//   Routes one granted host's A channel to the device selected by a base/mask
//   address map, and routes that device's D channel back to the host that
//   owns the path. Hosts are arbitrated round-robin whenever the path is idle.
//   Up to MaxOutstanding accepted requests may be unanswered at once. While
//   any request is outstanding, the owner may only keep issuing requests to
//   the same device, which keeps responses in order.
//
// Optional feature (macro XBAR_DECERR_EN):
//   When defined, unmapped requests go to a built-in error responder, which
//   answers with d_error = 1. When undefined, unmapped requests fall through
//   to device 0.
//
// Ports:
//   clk_i, rst_i      clock; asynchronous active-high reset
//   tl_h_i / tl_h_o   host-side request in / response out, one per host
//   tl_d_i / tl_d_o   device-side response in / request out, one per device
//   outstanding_o     number of accepted but unanswered requests
//   busy_o            outstanding_o != 0
// ----------------------------------------------------------------------------
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  // Default address map tables. They are sized for up to 64 devices and are
  // truncated to N entries at the point of use.
  localparam int MaxDefaultDev = 64;

  function automatic logic [MaxDefaultDev*32-1:0] dev_base_default();
    logic [MaxDefaultDev-1:0][31:0] tbl;
    tbl[0] = 32'h8000_0000;
    for (int i = 1; i < MaxDefaultDev; i++) begin
      tbl[i] = 32'hC000_0000 + (32'(i - 1) << 12);
    end
    return tbl;
  endfunction

  function automatic logic [MaxDefaultDev*32-1:0] dev_mask_default();
    logic [MaxDefaultDev-1:0][31:0] tbl;
    tbl[0] = 32'hC000_0000;
    for (int i = 1; i < MaxDefaultDev; i++) begin
      tbl[i] = 32'hFFFF_F000;
    end
    return tbl;
  endfunction

endpackage

module tlul_xbar_mn
  import tlul_pkg::*;
#(
  parameter int M              = 2,
  parameter int N              = 8,
  parameter int MaxOutstanding = 4,
  parameter logic [N-1:0][31:0] DevBase = (N*32)'(tlul_pkg::dev_base_default()),
  parameter logic [N-1:0][31:0] DevMask = (N*32)'(tlul_pkg::dev_mask_default())
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  tl_h2d_t                           tl_h_i [M],
  output tl_d2h_t                           tl_h_o [M],
  input  tl_d2h_t                           tl_d_i [N],
  output tl_h2d_t                           tl_d_o [N],
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                              busy_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int HW   = (M > 1) ? $clog2(M) : 1;
  // One extra code point so that index N can name the error responder.
  localparam int TW   = $clog2(N + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
`ifdef XBAR_DECERR_EN
  localparam logic [TW-1:0] ErrTarget = TW'(N);
`endif

  // Registered state
  logic [HW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   target_q, target_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_hold_q, a_hold_d;
`ifdef XBAR_DECERR_EN
  logic            err_pend_q, err_pend_d;
  logic [2:0]      err_opcode_q, err_opcode_d;
  logic [1:0]      err_size_q, err_size_d;
  logic [7:0]      err_source_q, err_source_d;
`endif

  // Combinational path signals
  logic [HW-1:0] grant;
  logic          grant_found;
  tl_h2d_t       sel_a;
  logic          owner_d_ready;
  logic [TW-1:0] dec;
  logic          busy;
  logic          lock_stall, limit_stall, err_stall;
  logic          a_allow, fwd_valid, dev_a_ready, host_a_ready, a_hs;
  tl_d2h_t       d_sel;
  logic          d_ready_fwd, d_hs;

  assign busy = (cnt_q != '0);

  // Round-robin search from rr_ptr, only while the path is idle and no
  // presented request is waiting for acceptance.
  always_comb begin
    grant       = owner_q;
    grant_found = 1'b0;
    if (cnt_q == '0 && !a_hold_q) begin
      for (int k = 0; k < M; k++) begin
        for (int j = 0; j < M; j++) begin
          if (!grant_found && tl_h_i[j].a_valid &&
              (j == (int'(rr_ptr_q) + k) % M)) begin
            grant       = HW'(j);
            grant_found = 1'b1;
          end
        end
      end
    end
  end

  // Host-side muxes: request of the granted host, d_ready of the owner.
  always_comb begin
    sel_a         = '0;
    owner_d_ready = 1'b0;
    for (int j = 0; j < M; j++) begin
      if (HW'(j) == grant)   sel_a         = tl_h_i[j];
      if (HW'(j) == owner_q) owner_d_ready = tl_h_i[j].d_ready;
    end
  end

  // Address decode; scanning downward lets the lowest hitting index win.
  always_comb begin
`ifdef XBAR_DECERR_EN
    dec = ErrTarget;
`else
    dec = '0;
`endif
    for (int i = N - 1; i >= 0; i--) begin
      if ((sel_a.a_address & DevMask[i]) == DevBase[i]) dec = TW'(i);
    end
  end

  // Gating of the A path. The limit also hides a_valid from the device, so a
  // device can never complete a handshake the host side did not see.
  always_comb begin
    lock_stall  = busy && (dec != target_q);
    limit_stall = (cnt_q == CntMax);
`ifdef XBAR_DECERR_EN
    err_stall   = (dec == ErrTarget) && (busy || err_pend_q);
`else
    err_stall   = 1'b0;
`endif
    a_allow     = !rst_i && !lock_stall && !limit_stall && !err_stall;
    fwd_valid   = a_allow && sel_a.a_valid;
    // The error responder is always ready once allowed.
    dev_a_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (dec == TW'(i)) dev_a_ready = tl_d_i[i].a_ready;
    end
    host_a_ready = a_allow && dev_a_ready;
    a_hs         = fwd_valid && dev_a_ready;
  end

  // D path from the current target. Nothing is forwarded while no request is
  // outstanding, so stale responses after a reset stay blocked.
  always_comb begin
    d_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (target_q == TW'(i)) d_sel = tl_d_i[i];
    end
`ifdef XBAR_DECERR_EN
    if (target_q == ErrTarget) begin
      d_sel          = '0;
      d_sel.d_valid  = err_pend_q;
      d_sel.d_opcode = err_opcode_q;
      d_sel.d_size   = err_size_q;
      d_sel.d_source = err_source_q;
      d_sel.d_error  = 1'b1;
    end
`endif
    d_sel.d_valid = d_sel.d_valid && busy && !rst_i;
    d_sel.a_ready = 1'b0;
    d_ready_fwd   = owner_d_ready && busy && !rst_i;
    d_hs          = d_sel.d_valid && d_ready_fwd;
  end

  // Output drive
  always_comb begin
    for (int j = 0; j < M; j++) begin
      tl_h_o[j] = '0;
      if (HW'(j) == owner_q) tl_h_o[j] = d_sel;
      tl_h_o[j].a_ready = (HW'(j) == grant) && host_a_ready;
    end
    for (int i = 0; i < N; i++) begin
      tl_d_o[i]         = sel_a;
      tl_d_o[i].a_valid = fwd_valid && (dec == TW'(i));
      tl_d_o[i].d_ready = d_ready_fwd && (target_q == TW'(i));
    end
    outstanding_o = rst_i ? '0 : cnt_q;
    busy_o        = !rst_i && busy;
  end

  // Next-state logic
  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    // Hold exactly while a presented request waits for the device.
    a_hold_d = fwd_valid && !dev_a_ready;
    if (a_hs) begin
      owner_d  = grant;
      rr_ptr_d = HW'((int'(grant) + 1) % M);
      target_d = dec;
    end else if (fwd_valid) begin
      // Freeze the grant in owner; this only changes owner when the path is
      // idle, so no outstanding response is re-routed.
      owner_d = grant;
    end
    case ({a_hs, d_hs})
      2'b10:   if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
      2'b01:   if (cnt_q != '0)     cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
`ifdef XBAR_DECERR_EN
    err_pend_d   = err_pend_q;
    err_opcode_d = err_opcode_q;
    err_size_d   = err_size_q;
    err_source_d = err_source_q;
    if (a_hs && dec == ErrTarget) begin
      err_pend_d   = 1'b1;
      err_opcode_d = (sel_a.a_opcode == Get) ? AccessAckData : AccessAck;
      err_size_d   = sel_a.a_size;
      err_source_d = sel_a.a_source;
    end else if (d_hs && target_q == ErrTarget) begin
      err_pend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      a_hold_q     <= 1'b0;
`ifdef XBAR_DECERR_EN
      err_pend_q   <= 1'b0;
      err_opcode_q <= '0;
      err_size_q   <= '0;
      err_source_q <= '0;
`endif
    end else begin
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      a_hold_q     <= a_hold_d;
`ifdef XBAR_DECERR_EN
      err_pend_q   <= err_pend_d;
      err_opcode_q <= err_opcode_d;
      err_size_q   <= err_size_d;
      err_source_q <= err_source_d;
`endif
    end
  end

endmodule

// File: tb/tb_tlul_xbar_mn.sv
// ----------------------------------------------------------------------------
// tb_tlul_xbar_mn -- directed self-checking bench for tlul_xbar_mn
// (M = 2, N = 8, MaxOutstanding = 4, default address map). Honours
// XBAR_DECERR_EN for the unmapped-address scenario.
// ----------------------------------------------------------------------------
module tb_tlul_xbar_mn;
  import tlul_pkg::*;

  logic    clk_i = 1'b0;
  logic    rst_i;
  tl_h2d_t h_i [2];
  tl_d2h_t h_o [2];
  tl_d2h_t d_i [8];
  tl_h2d_t d_o [8];
  logic [2:0] outstanding;
  logic       busy;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tlul_xbar_mn #(.M(2), .N(8), .MaxOutstanding(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tl_h_i       (h_i),
    .tl_h_o       (h_o),
    .tl_d_i       (d_i),
    .tl_d_o       (d_o),
    .outstanding_o(outstanding),
    .busy_o       (busy)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    for (int h = 0; h < 2; h++) begin
      h_i[h] = '0;
      h_i[h].d_ready = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      d_i[i] = '0;
      d_i[i].a_ready = 1'b1;
    end
  endtask

  task automatic drive_a(input int h, input logic [2:0] op, input logic [31:0] addr,
                         input logic [7:0] src);
    h_i[h].a_valid   = 1'b1;
    h_i[h].a_opcode  = op;
    h_i[h].a_size    = 2'd2;
    h_i[h].a_source  = src;
    h_i[h].a_address = addr;
    h_i[h].a_mask    = 4'hF;
    h_i[h].a_data    = 32'h1111_0000 + addr;
  endtask

  task automatic respond(input int dev, input logic [2:0] op, input logic [7:0] src,
                         input logic [31:0] data);
    d_i[dev].d_valid  = 1'b1;
    d_i[dev].d_opcode = op;
    d_i[dev].d_size   = 2'd2;
    d_i[dev].d_source = src;
    d_i[dev].d_data   = data;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_i = 1'b1;
    drive_a(0, Get, 32'h8000_0010, 8'd1);
    d_i[0].d_valid = 1'b1;
    #2;
    checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b want 0", h_o[0].a_ready); end
    checks++; if (d_o[0].a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b want 0", d_o[0].a_valid); end
    checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b want 0", h_o[0].d_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    idle_all();
    step();
    step();
    rst_i = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_release_outstanding got %0d want 0", outstanding); end
    $display("txn reset: outputs idle during and after reset");
  endtask

  task automatic test_get();
    drive_a(0, Get, 32'h8000_0010, 8'd3);
    #1;
    checks++; if (d_o[0].a_valid !== 1'b1) begin errors++; $display("FAIL get_dev0_a_valid got %b want 1", d_o[0].a_valid); end
    checks++; if (d_o[0].a_address !== 32'h8000_0010) begin errors++; $display("FAIL get_dev0_addr got %h want 80000010", d_o[0].a_address); end
    checks++; if (d_o[0].a_source !== 8'd3) begin errors++; $display("FAIL get_dev0_source got %0d want 3", d_o[0].a_source); end
    checks++; if (d_o[1].a_valid !== 1'b0) begin errors++; $display("FAIL get_dev1_a_valid got %b want 0", d_o[1].a_valid); end
    checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL get_h0_a_ready got %b want 1", h_o[0].a_ready); end
    checks++; if (h_o[1].a_ready !== 1'b0) begin errors++; $display("FAIL get_h1_a_ready got %b want 0", h_o[1].a_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL get_cnt_before got %0d want 0", outstanding); end
    step();
    h_i[0].a_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL get_cnt_after_a got %0d want 1", outstanding); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL get_busy got %b want 1", busy); end
    step();
    respond(0, AccessAckData, 8'd3, 32'hCAFE_0001);
    #1;
    checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL get_h0_d_valid got %b want 1", h_o[0].d_valid); end
    checks++; if (h_o[0].d_opcode !== AccessAckData) begin errors++; $display("FAIL get_d_opcode got %0d want 1", h_o[0].d_opcode); end
    checks++; if (h_o[0].d_source !== 8'd3) begin errors++; $display("FAIL get_d_source got %0d want 3", h_o[0].d_source); end
    checks++; if (h_o[0].d_data !== 32'hCAFE_0001) begin errors++; $display("FAIL get_d_data got %h want cafe0001", h_o[0].d_data); end
    checks++; if (h_o[1].d_valid !== 1'b0) begin errors++; $display("FAIL get_h1_d_valid got %b want 0", h_o[1].d_valid); end
    checks++; if (d_o[0].d_ready !== 1'b1) begin errors++; $display("FAIL get_dev0_d_ready got %b want 1", d_o[0].d_ready); end
    checks++; if (d_o[1].d_ready !== 1'b0) begin errors++; $display("FAIL get_dev1_d_ready got %b want 0", d_o[1].d_ready); end
    step();
    d_i[0].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL get_cnt_end got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL get_busy_end got %b want 0", busy); end
    $display("txn get: host0 -> dev0 addr 80000010 src 3, AccessAckData returned");
  endtask

  // Both hosts keep requesting. After each grant the winner retargets to the
  // other of device 1 / device 2, so the ordering lock holds it off until the
  // response drains and the other host gets its turn.
  task automatic test_round_robin();
    logic [31:0] addr_tbl [2];
    int cur [2];
    int exp_h, dev;
    addr_tbl[0] = 32'hC000_0000;
    addr_tbl[1] = 32'hC000_1000;
    cur[0] = 0;
    cur[1] = 0;
    do_reset();
    drive_a(0, PutFullData, addr_tbl[0], 8'd10);
    drive_a(1, PutFullData, addr_tbl[0], 8'd11);
    for (int t = 0; t < 4; t++) begin
      exp_h = t % 2;
      dev   = cur[exp_h] + 1;
      #1;
      checks++; if (h_o[exp_h].a_ready !== 1'b1) begin errors++; $display("FAIL rr_winner_ready t%0d got %b want 1", t, h_o[exp_h].a_ready); end
      checks++; if (h_o[1-exp_h].a_ready !== 1'b0) begin errors++; $display("FAIL rr_loser_ready t%0d got %b want 0", t, h_o[1-exp_h].a_ready); end
      checks++; if (d_o[dev].a_source !== 8'(10 + exp_h)) begin errors++; $display("FAIL rr_source t%0d got %0d want %0d", t, d_o[dev].a_source, 10 + exp_h); end
      step();
      cur[exp_h] = 1 - cur[exp_h];
      h_i[exp_h].a_address = addr_tbl[cur[exp_h]];
      respond(dev, AccessAck, 8'(10 + exp_h), 32'h0);
      #1;
      checks++; if (h_o[exp_h].a_ready !== 1'b0) begin errors++; $display("FAIL rr_lock_ready t%0d got %b want 0", t, h_o[exp_h].a_ready); end
      checks++; if (d_o[cur[exp_h] + 1].a_valid !== 1'b0) begin errors++; $display("FAIL rr_lock_a_valid t%0d got %b want 0", t, d_o[cur[exp_h] + 1].a_valid); end
      checks++; if (h_o[exp_h].d_valid !== 1'b1) begin errors++; $display("FAIL rr_d_valid t%0d got %b want 1", t, h_o[exp_h].d_valid); end
      step();
      d_i[dev].d_valid = 1'b0;
      $display("txn rr %0d: granted host %0d to dev %0d", t, exp_h, dev);
    end
    idle_all();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rr_cnt_end got %0d want 0", outstanding); end
  endtask

  task automatic test_limit();
    drive_a(0, PutFullData, 32'hC000_1000, 8'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL limit_ready_%0d got %b want 1", k, h_o[0].a_ready); end
      checks++; if (outstanding !== 3'(k)) begin errors++; $display("FAIL limit_cnt_%0d got %0d want %0d", k, outstanding, k); end
      step();
      $display("txn limit: put %0d accepted", k);
    end
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL limit_cnt_sat got %0d want 4", outstanding); end
    checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL limit_5th_ready got %b want 0", h_o[0].a_ready); end
    checks++; if (d_o[2].a_valid !== 1'b0) begin errors++; $display("FAIL limit_5th_a_valid got %b want 0", d_o[2].a_valid); end
    step();
    respond(2, AccessAck, 8'd2, 32'h0);
    #1;
    checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL limit_ready_with_d got %b want 0", h_o[0].a_ready); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL limit_cnt_hold got %0d want 4", outstanding); end
    step();
    d_i[2].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL limit_cnt_drop got %0d want 3", outstanding); end
    checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL limit_5th_ready_late got %b want 1", h_o[0].a_ready); end
    step();
    h_i[0].a_valid = 1'b0;
    $display("txn limit: put 4 accepted after first response");
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL limit_cnt_refill got %0d want 4", outstanding); end
    respond(2, AccessAck, 8'd2, 32'h0);
    for (int k = 0; k < 4; k++) step();
    d_i[2].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL limit_cnt_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_lock();
    drive_a(0, PutFullData, 32'hC000_1000, 8'd4);
    #1;
    checks++; if (d_o[2].a_valid !== 1'b1) begin errors++; $display("FAIL lock_first_dev2 got %b want 1", d_o[2].a_valid); end
    step();
    h_i[0].a_address = 32'hC000_2000;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL lock_stall_ready_%0d got %b want 0", k, h_o[0].a_ready); end
      checks++; if (d_o[3].a_valid !== 1'b0) begin errors++; $display("FAIL lock_stall_dev3_%0d got %b want 0", k, d_o[3].a_valid); end
      checks++; if (d_o[2].a_valid !== 1'b0) begin errors++; $display("FAIL lock_stall_dev2_%0d got %b want 0", k, d_o[2].a_valid); end
      step();
    end
    respond(2, AccessAck, 8'd4, 32'h0);
    #1;
    checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL lock_ready_during_d got %b want 0", h_o[0].a_ready); end
    step();
    d_i[2].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL lock_drained got %0d want 0", outstanding); end
    checks++; if (d_o[3].a_valid !== 1'b1) begin errors++; $display("FAIL lock_dev3_valid got %b want 1", d_o[3].a_valid); end
    checks++; if (d_o[2].a_valid !== 1'b0) begin errors++; $display("FAIL lock_dev2_quiet got %b want 0", d_o[2].a_valid); end
    checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL lock_ready_after got %b want 1", h_o[0].a_ready); end
    step();
    h_i[0].a_valid = 1'b0;
    respond(3, AccessAck, 8'd4, 32'h0);
    step();
    d_i[3].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL lock_cnt_end got %0d want 0", outstanding); end
    $display("txn lock: dev2 put then dev3 put after drain");
  endtask

  task automatic test_decerr();
    drive_a(0, Get, 32'h0000_0100, 8'd5);
    #1;
`ifdef XBAR_DECERR_EN
    checks++; if (d_o[0].a_valid !== 1'b0) begin errors++; $display("FAIL decerr_dev0_quiet got %b want 0", d_o[0].a_valid); end
    checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL decerr_ready got %b want 1", h_o[0].a_ready); end
    step();
    h_i[0].a_valid = 1'b0;
    #1;
    checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL decerr_d_valid got %b want 1", h_o[0].d_valid); end
    checks++; if (h_o[0].d_error !== 1'b1) begin errors++; $display("FAIL decerr_d_error got %b want 1", h_o[0].d_error); end
    checks++; if (h_o[0].d_opcode !== AccessAckData) begin errors++; $display("FAIL decerr_d_opcode got %0d want 1", h_o[0].d_opcode); end
    checks++; if (h_o[0].d_source !== 8'd5) begin errors++; $display("FAIL decerr_d_source got %0d want 5", h_o[0].d_source); end
    checks++; if (h_o[0].d_data !== 32'h0) begin errors++; $display("FAIL decerr_d_data got %h want 0", h_o[0].d_data); end
    step();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL decerr_cnt_end got %0d want 0", outstanding); end
    checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL decerr_d_valid_end got %b want 0", h_o[0].d_valid); end
    $display("txn decerr: unmapped get src 5 answered with error");
`else
    checks++; if (d_o[0].a_valid !== 1'b1) begin errors++; $display("FAIL unmapped_dev0_valid got %b want 1", d_o[0].a_valid); end
    checks++; if (d_o[0].a_address !== 32'h0000_0100) begin errors++; $display("FAIL unmapped_addr got %h want 00000100", d_o[0].a_address); end
    checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL unmapped_ready got %b want 1", h_o[0].a_ready); end
    step();
    h_i[0].a_valid = 1'b0;
    respond(0, AccessAckData, 8'd5, 32'h0);
    step();
    d_i[0].d_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL unmapped_cnt_end got %0d want 0", outstanding); end
    $display("txn unmapped: get src 5 routed to dev0");
`endif
  endtask

  task automatic test_reset_mid();
    drive_a(0, Get, 32'h8000_0000, 8'd6);
    step();
    step();
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL rstmid_cnt got %0d want 2", outstanding); end
    respond(0, AccessAckData, 8'd6, 32'h0);
    rst_i = 1'b1;
    #1;
    checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL rstmid_a_ready got %b want 0", h_o[0].a_ready); end
    checks++; if (d_o[0].a_valid !== 1'b0) begin errors++; $display("FAIL rstmid_a_valid got %b want 0", d_o[0].a_valid); end
    checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rstmid_d_valid got %b want 0", h_o[0].d_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rstmid_outstanding got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    step();
    rst_i = 1'b0;
    h_i[0].a_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rstmid_release_cnt got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_release_busy got %b want 0", busy); end
    checks++; if (d_o[0].d_ready !== 1'b0) begin errors++; $display("FAIL rstmid_stale_d_ready got %b want 0", d_o[0].d_ready); end
    checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_d_valid got %b want 0", h_o[0].d_valid); end
    step();
    idle_all();
    $display("txn reset_mid: two in flight dropped by reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    idle_all();
    test_reset();
    test_get();
    test_round_robin();
    test_limit();
    test_lock();
    test_decerr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
